// File: rtl/rofofo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rofofo_pkg
// Purpose  : Shared types and sizing helpers for the I2S sample packer.
//            PACKER_COMPRESS_EN selects 16-bit (2-byte) output samples.
// Revision : 1.0 - initial release
// ============================================================================
package rofofo_pkg;

  localparam int c_byte_w = 8;

  typedef logic [c_byte_w-1:0] byte_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Right-shift amount that divides by the block-average length.
  function automatic int f_rf_shift(input int reduce_factor);
    return $clog2(reduce_factor);
  endfunction

  // Number of bytes sent per averaged sample.
  function automatic int f_nbytes(input int data_size);
`ifdef PACKER_COMPRESS_EN
    return 2;
`else
    return data_size / c_byte_w;
`endif
  endfunction

endpackage : rofofo_pkg
`default_nettype wire

// File: rtl/sample_averager.sv
`default_nettype none
// ============================================================================
// Module   : sample_averager
// Purpose  : Block-averages REDUCE_FACTOR signed samples. avg_done strobes
//            combinationally with the last sample of each block, with
//            avg_data holding the floor-divided average in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sample_averager
  import rofofo_pkg::*;
#(
  parameter int DATA_SIZE     = 24,
  parameter int REDUCE_FACTOR = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [DATA_SIZE-1:0] sample_data,
  output logic                 avg_done,
  output logic [DATA_SIZE-1:0] avg_data
);

  localparam int c_shift = f_rf_shift(REDUCE_FACTOR);
  localparam int c_acc_w = DATA_SIZE + c_shift;
  localparam int c_cnt_w = (c_shift > 0) ? c_shift : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(REDUCE_FACTOR - 1);

  logic signed [c_acc_w-1:0] r_acc;
  logic        [c_cnt_w-1:0] r_cnt;
  logic signed [c_acc_w-1:0] w_sext;
  logic signed [c_acc_w-1:0] w_sum;

  // Sign-extend the incoming sample to accumulator width; the accumulator
  // is wide enough that a full block of samples can never overflow.
  assign w_sext   = c_acc_w'($signed(sample_data));
  assign w_sum    = r_acc + w_sext;
  assign avg_done = sample_valid && (r_cnt == c_last_cnt);
  // Arithmetic shift floors toward negative infinity.
  assign avg_data = DATA_SIZE'(w_sum >>> c_shift);

  // Accumulate each strobe; clear accumulator and counter on block completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (sample_valid) begin
      if (avg_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : sample_averager
`default_nettype wire

// File: rtl/i2s_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_packer
// Purpose  : Decimates I2S PCM samples by block averaging and serialises each
//            average MSB-first onto a byte valid/ready stream. Averages that
//            complete while the serializer is busy are dropped and counted.
//            Define PACKER_COMPRESS_EN to send only the top 16 bits (2 bytes).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_packer
  import rofofo_pkg::*;
#(
  parameter int DATA_SIZE     = 24,
  parameter int REDUCE_FACTOR = 2,
  parameter int FIFO_WIDTH    = 8,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_SIZE-1:0]  sample_data,
  output logic                  byte_valid,
  output logic [FIFO_WIDTH-1:0] byte_data,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int c_nbytes = f_nbytes(DATA_SIZE);
  localparam int c_hold_w = c_nbytes * FIFO_WIDTH;
  localparam int c_idx_w  = $clog2(c_nbytes);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nbytes - 1);

  logic                  w_avg_done;
  logic [DATA_SIZE-1:0]  w_avg_data;
  logic [c_hold_w-1:0]   w_load_val;
  logic                  w_fire;
  logic                  w_last_hs;

  ser_state_t            r_state;
  logic [c_hold_w-1:0]   r_hold;
  logic [c_idx_w-1:0]    r_idx;
  logic                  r_valid;
  logic [DROP_CNT_W-1:0] r_drop;

  sample_averager #(
    .DATA_SIZE     (DATA_SIZE),
    .REDUCE_FACTOR (REDUCE_FACTOR)
  ) u_avg (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .avg_done     (w_avg_done),
    .avg_data     (w_avg_data)
  );

  // Keep the top c_hold_w bits of the average; in full mode this is all of it,
  // in compressed mode the low bits are truncated without rounding.
  assign w_load_val = c_hold_w'(w_avg_data >> (DATA_SIZE - c_hold_w));

  assign w_fire    = r_valid && byte_ready;
  assign w_last_hs = w_fire && (r_idx == c_last_idx);

  // The hold register shifts left per accepted byte, so its top byte is
  // always hold[DATA_SIZE-1-8*index -: 8] of the originally loaded value.
  assign byte_data  = r_hold[c_hold_w-1 -: FIFO_WIDTH];
  assign byte_valid = r_valid;
  assign busy       = (r_state == SEND);
  assign drop_count = r_drop;

  // Serializer FSM: load an average, emit it byte by byte, reload back-to-back
  // when a new average lands on the final handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_avg_done) begin
            r_state <= SEND;
            r_hold  <= w_load_val;
            r_idx   <= '0;
            r_valid <= 1'b1;
          end
        end
        SEND: begin
          if (w_last_hs) begin
            if (w_avg_done) begin
              r_hold  <= w_load_val;
              r_idx   <= '0;
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end else if (w_fire) begin
            r_hold <= r_hold << FIFO_WIDTH;
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count averages that arrive while a sample is still in flight; saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_avg_done && (r_state == SEND) && !w_last_hs && (r_drop != '1)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

endmodule : i2s_sample_packer
`default_nettype wire

// File: tb/tb_i2s_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_sample_packer
// Purpose  : Directed, table-driven bench for i2s_sample_packer
//            (DATA_SIZE=24, REDUCE_FACTOR=2). Honours PACKER_COMPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_packer;

`ifdef PACKER_COMPRESS_EN
  localparam int NB = 2;
`else
  localparam int NB = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [23:0] sample_data;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        busy;
  logic [7:0]  drop_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [23:0] s0;
    logic [23:0] s1;
    logic [23:0] avg;
  } vec_t;

  vec_t tbl [7];

  i2s_sample_packer #(
    .DATA_SIZE     (24),
    .REDUCE_FACTOR (2),
    .FIFO_WIDTH    (8),
    .DROP_CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [23:0] avg, input int k);
    logic [23:0] v;
    v = avg;
    return v[23-8*k -: 8];
  endfunction

  // Called just after the load edge with byte_ready=1: expect NB bytes back-to-back.
  task automatic check_sample(input string name, input logic [23:0] avg);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("%s valid[%0d]", name, k), {31'd0, byte_valid}, 32'd1);
      check($sformatf("%s busy[%0d]", name, k), {31'd0, busy}, 32'd1);
      check($sformatf("%s byte[%0d]", name, k), {24'd0, byte_data}, {24'd0, exp_byte(avg, k)});
      step();
    end
    check($sformatf("%s idle valid", name), {31'd0, byte_valid}, 32'd0);
    check($sformatf("%s idle busy", name), {31'd0, busy}, 32'd0);
  endtask

  task automatic feed_pair(input logic [23:0] a, input logic [23:0] b);
    sample_valid = 1'b1;
    sample_data  = a;
    step();
    sample_data  = b;
    step();
    sample_valid = 1'b0;
    sample_data  = '0;
  endtask

  initial begin
    tbl[0] = '{24'h000010, 24'h000020, 24'h000018};
    tbl[1] = '{24'hFFFFF0, 24'hFFFFE0, 24'hFFFFE8};
    tbl[2] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
    tbl[3] = '{24'h800000, 24'h800000, 24'h800000};
    tbl[4] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    tbl[5] = '{24'h000001, 24'h000002, 24'h000001};
    tbl[6] = '{24'h123456, 24'h123458, 24'h123457};

    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    byte_ready   = 1'b1;
    step();
    step();
    check("reset byte_valid", {31'd0, byte_valid}, 32'd0);
    check("reset byte_data", {24'd0, byte_data}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset drop_count", {24'd0, drop_count}, 32'd0);
    rst = 1'b0;
    step();

    // Table-driven averages with the FIFO always ready.
    for (int i = 0; i < 7; i++) begin
      sample_valid = 1'b1;
      sample_data  = tbl[i].s0;
      step();
      check($sformatf("vec%0d no early valid", i), {31'd0, byte_valid}, 32'd0);
      sample_data = tbl[i].s1;
      step();
      sample_valid = 1'b0;
      sample_data  = '0;
      check_sample($sformatf("vec%0d", i), tbl[i].avg);
    end
    check("no drops after table", {24'd0, drop_count}, 32'd0);

    // Backpressure: first byte held for 5 cycles.
    byte_ready = 1'b0;
    feed_pair(24'h000010, 24'h000020);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold valid c%0d", c), {31'd0, byte_valid}, 32'd1);
      check($sformatf("bp hold byte c%0d", c), {24'd0, byte_data}, 32'h00);
      step();
    end
    byte_ready = 1'b1;
    check_sample("bp release", 24'h000018);
    check("bp drop_count", {24'd0, drop_count}, 32'd0);

    // Back-to-back: next average completes exactly on the last handshake.
    feed_pair(24'h000010, 24'h000020);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("b2b A valid[%0d]", k), {31'd0, byte_valid}, 32'd1);
      check($sformatf("b2b A byte[%0d]", k), {24'd0, byte_data}, {24'd0, exp_byte(24'h000018, k)});
      sample_valid = 1'b0;
      sample_data  = '0;
      if (k == NB - 2) begin
        sample_valid = 1'b1;
        sample_data  = 24'hFFFFF0;
      end else if (k == NB - 1) begin
        sample_valid = 1'b1;
        sample_data  = 24'hFFFFE0;
      end
      step();
    end
    sample_valid = 1'b0;
    sample_data  = '0;
    check_sample("b2b B", 24'hFFFFE8);
    check("b2b drop_count", {24'd0, drop_count}, 32'd0);

    // Drop saturation: FIFO stalled, 300 averages, only the first survives.
    byte_ready = 1'b0;
    feed_pair(24'h111110, 24'h111112);
    for (int i = 0; i < 299; i++) begin
      feed_pair(24'h000000, 24'h000000);
      if (i == 9) check("drop count after 10", {24'd0, drop_count}, 32'd10);
    end
    check("drop saturated", {24'd0, drop_count}, 32'd255);
    check("drop held valid", {31'd0, byte_valid}, 32'd1);
    check("drop held byte", {24'd0, byte_data}, 32'h11);
    byte_ready = 1'b1;
    check_sample("drop release", 24'h111111);
    check("drop stays saturated", {24'd0, drop_count}, 32'd255);

    // Reset mid-average, with a strobe during reset that must be ignored.
    sample_valid = 1'b1;
    sample_data  = 24'h000100;
    step();
    sample_data = 24'h007777;
    rst         = 1'b1;
    step();
    rst          = 1'b0;
    sample_valid = 1'b0;
    check("post-rst drop_count", {24'd0, drop_count}, 32'd0);
    check("post-rst valid", {31'd0, byte_valid}, 32'd0);
    check("post-rst busy", {31'd0, busy}, 32'd0);
    sample_valid = 1'b1;
    sample_data  = 24'h000002;
    step();
    check("post-rst first strobe no valid", {31'd0, byte_valid}, 32'd0);
    sample_data = 24'h000004;
    step();
    sample_valid = 1'b0;
    sample_data  = '0;
    check_sample("post-rst avg", 24'h000003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_i2s_sample_packer
`default_nettype wire

// File: doc/i2s_sample_packer.md
Name: i2s_sample_packer

Overview:
- Sits between the I2S capture stage and the 8-bit sample FIFO in the microphone capture path.
- Averages every REDUCE_FACTOR incoming signed PCM samples (decimation by block averaging).
- Serialises each averaged sample MSB-first into bytes on a valid/ready stream that pushes into the FIFO.
- Counts samples dropped because the FIFO side applied backpressure.

Parameters:
- DATA_SIZE, 24: sample width in bits; must be a multiple of 8, minimum 16.
- REDUCE_FACTOR, 2: samples averaged per output; must be a power of two, minimum 1.
- FIFO_WIDTH, 8: output byte width; fixed at 8.
- DROP_CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_valid  in  1  one-cycle strobe; sample_data is valid in that cycle.
- sample_data  in  DATA_SIZE  signed two's-complement PCM sample.
- byte_valid  out  1  output byte available.
- byte_data  out  FIFO_WIDTH  output byte.
- byte_ready  in  1  downstream accepts the byte (driven by FIFO not full).
- busy  out  1  serializer holds an unsent sample.
- drop_count  out  DROP_CNT_W  saturating count of averaged samples lost.

Behaviour:
- Interface decided: single clock clk; reset rst is synchronous and active-high.
- Reset values: byte_valid=0, byte_data=0, busy=0, drop_count=0, accumulator=0, sample counter=0, state=IDLE, byte index=0.
- Accumulator width is DATA_SIZE+log2(REDUCE_FACTOR), with sign extension.
- On each sample_valid the sample is added to the accumulator and the counter increments.
- On the REDUCE_FACTOR-th sample: avg = (acc + sample) >>> log2(REDUCE_FACTOR).
  - Arithmetic shift, truncation toward negative infinity.
  - avg is DATA_SIZE wide.
  - The accumulator and counter clear in the same cycle.
- With REDUCE_FACTOR=1, avg equals sample.
- Latency: avg is loaded into the hold register on the edge of the REDUCE_FACTOR-th strobe; byte_valid rises the next cycle.
- Serializer FSM:
  - IDLE: byte_valid=0. Load of a new avg moves to SEND with index=0.
  - SEND: byte_valid=1; byte_data = hold[DATA_SIZE-1-8*index -: 8].
  - On byte_valid&&byte_ready: index++.
  - On the last index with handshake: go to IDLE, unless a new avg loads in the same cycle. In that case stay in SEND with index=0 (back-to-back, no bubble).
- Bytes per sample: NBYTES = DATA_SIZE/8, MSB first.
- Handshake: byte_data stays stable while byte_valid=1 and byte_ready=0. byte_valid never drops without a handshake.
- busy = (state==SEND).
- Overflow: if a new avg completes while in SEND and it is not the last-byte handshake cycle:
  - The new avg is discarded.
  - drop_count increments, saturating at all-ones.
  - The in-flight sample is unaffected.
- The accumulator always keeps averaging; input is never stalled, since I2S cannot be back-pressured.
- Reset mid-operation: any partial average and in-flight bytes are discarded. The first average after reset uses only post-reset samples.
- sample_valid asserted during rst is ignored.

Optional Feature:
- Macro PACKER_COMPRESS_EN.
- Defined: only avg[DATA_SIZE-1 -: 16] is stored and sent, giving 2 bytes per sample, MSB first. Lower bits are truncated with no rounding.
- Undefined: all DATA_SIZE/8 bytes are sent.
- Drop and handshake rules are identical in both modes.

Decomposition:
- Package rofofo_pkg holds:
  - byte_t (logic [7:0]).
  - Serializer state enum {IDLE, SEND}.
  - Constants NBYTES and RF_SHIFT, or function forms computing them from the parameters.
- Natural sub-module: sample_averager, covering the accumulator, counter and avg output with a done strobe.
- Serializer and drop counter stay in i2s_sample_packer.

Test Plan:
- RF=2, byte_ready=1; samples 0x000010, 0x000020 -> bytes 0x00, 0x00, 0x18 on consecutive cycles; byte_valid rises one cycle after the second strobe.
- Negative: samples 0xFFFFF0, 0xFFFFE0 -> avg -24 -> bytes 0xFF, 0xFF, 0xE8.
- Backpressure: byte_ready=0 for 5 cycles after the first byte appears -> byte_data held at 0x00, byte_valid=1; after release, remaining bytes follow and drop_count stays 0.
- Drop: byte_ready=0, feed 300 sample pairs -> the first average is retained and sent after release; drop_count saturates at 255.
- Reset mid-average: sample 0x000100, assert rst for 1 cycle, then samples 0x000002, 0x000004 -> bytes 0x00, 0x00, 0x03.
- PACKER_COMPRESS_EN defined: samples 0x123456, 0x123458 -> exactly two bytes 0x12, 0x34, then IDLE; back-to-back averages produce no idle cycle between samples.
